// File: rtl/cmplx_pkg.sv
// Shared width, rounding and saturation helpers for the pipelined complex multiplier.
package cmplx_pkg;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw;
    endfunction

    function automatic int sum_w(input int dw, input int tw);
        return dw + tw + 1;
    endfunction

    function automatic longint rnd_const(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe_if.sv
// Operand/result stream with valid/ready handshakes plus the overflow counter controls.
interface cmplx_mult_pipe_if #(
    parameter int DW = 16,
    parameter int TW = 16,
    parameter int OW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 conj_en;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic signed [TW-1:0] w_re;
    logic signed [TW-1:0] w_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic                 ovf_clr;
    logic [15:0]          ovf_cnt;

    modport master (
        output in_valid, conj_en, a_re, a_im, w_re, w_im, out_ready, ovf_clr,
        input  in_ready, out_valid, out_re, out_im, ovf_cnt
    );

    modport slave (
        input  in_valid, conj_en, a_re, a_im, w_re, w_im, out_ready, ovf_clr,
        output in_ready, out_valid, out_re, out_im, ovf_cnt
    );
endinterface

// File: rtl/cmplx_round_sat.sv
// Round-half-up, arithmetic right shift by FRAC and clamp to an OW-bit signed range.
module cmplx_round_sat
    import cmplx_pkg::*;
#(
    parameter int IW   = 33,
    parameter int FRAC = 15,
    parameter int OW   = 16
) (
    input  logic signed [IW-1:0] sum,
    output logic signed [OW-1:0] value,
    output logic                 sat
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int EW = IW + 1;
    localparam logic signed [EW-1:0] RND  = EW'(rnd_const(FRAC));
    localparam logic signed [EW-1:0] HI   = EW'(sat_max(OW));
    localparam logic signed [EW-1:0] LO   = EW'(sat_min(OW));
    localparam logic signed [OW-1:0] OMAX = OW'(sat_max(OW));
    localparam logic signed [OW-1:0] OMIN = OW'(sat_min(OW));

    function automatic logic signed [EW-1:0] round_shift(input logic signed [IW-1:0] x);
        logic signed [EW-1:0] t;
        t = $signed({x[IW-1], x}) + RND;
        return t >>> FRAC;
    endfunction

    logic signed [EW-1:0] shifted;

    always_comb begin
        shifted = round_shift(sum);
        sat     = 1'b0;
        value   = shifted[OW-1:0];
        if (shifted > HI) begin
            sat   = 1'b1;
            value = OMAX;
        end else if (shifted < LO) begin
            sat   = 1'b1;
            value = OMIN;
        end
    end
endmodule

// File: rtl/cmplx_mult_pipe.sv
// Three-stage complex multiplier a*w or a*conj(w) with a global stall enable and sticky overflow count.
module cmplx_mult_pipe
    import cmplx_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int OW   = 16,
    parameter int FRAC = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    cmplx_mult_pipe_if.slave bus
);
    localparam int PW = prod_w(DW, TW);
    localparam int SW = sum_w(DW, TW);

    logic                 en;
    logic                 vld_p0, vld_p1, vld_p2;
    logic                 conj_p0, conj_p1;
    logic signed [DW-1:0] a_re_p0, a_im_p0;
    logic signed [TW-1:0] w_re_p0, w_im_p0;
    logic signed [PW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [OW-1:0] rs_re, rs_im;
    logic                 sat_re, sat_im;
    logic signed [OW-1:0] out_re_p2, out_im_p2;
    logic                 sat_p2;
    logic [15:0]          ovf_count;

    assign en = !vld_p2 || bus.out_ready;

    // Control and output registers: cleared asynchronously so in-flight beats vanish on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            sat_p2    <= 1'b0;
            out_re_p2 <= '0;
            out_im_p2 <= '0;
        end else if (en) begin
            vld_p0    <= bus.in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            sat_p2    <= sat_re || sat_im;
            out_re_p2 <= rs_re;
            out_im_p2 <= rs_im;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // Stage 1: operand capture
            a_re_p0 <= bus.a_re;
            a_im_p0 <= bus.a_im;
            w_re_p0 <= bus.w_re;
            w_im_p0 <= bus.w_im;
            conj_p0 <= bus.conj_en;
            // Stage 2: full-precision partial products
            rr_p1   <= PW'(a_re_p0) * PW'(w_re_p0);
            ii_p1   <= PW'(a_im_p0) * PW'(w_im_p0);
            ri_p1   <= PW'(a_re_p0) * PW'(w_im_p0);
            ir_p1   <= PW'(a_im_p0) * PW'(w_re_p0);
            conj_p1 <= conj_p0;
        end
    end

    // Stage 3: combine, round and clamp ahead of the output register
    always_comb begin
        if (conj_p1) begin
            sum_re = SW'(rr_p1) + SW'(ii_p1);
            sum_im = SW'(ir_p1) - SW'(ri_p1);
        end else begin
            sum_re = SW'(rr_p1) - SW'(ii_p1);
            sum_im = SW'(ri_p1) + SW'(ir_p1);
        end
    end

    cmplx_round_sat #(.IW(SW), .FRAC(FRAC), .OW(OW)) u_rs_re (
        .sum   (sum_re),
        .value (rs_re),
        .sat   (sat_re)
    );

    cmplx_round_sat #(.IW(SW), .FRAC(FRAC), .OW(OW)) u_rs_im (
        .sum   (sum_im),
        .value (rs_im),
        .sat   (sat_im)
    );

    // Clear wins over a same-cycle saturated handshake; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (bus.ovf_clr) begin
            ovf_count <= '0;
        end else if (vld_p2 && bus.out_ready && sat_p2 && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p2;
    assign bus.out_re    = out_re_p2;
    assign bus.out_im    = out_im_p2;
    assign bus.ovf_cnt   = ovf_count;
endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Self-checking bench for cmplx_mult_pipe: directed vectors plus a randomized backpressure stream.
module tb_cmplx_mult_pipe;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int OW   = 16;
    localparam int FRAC = 15;

    typedef struct {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
        bit                   sat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    cmplx_mult_pipe_if #(.DW(DW), .TW(TW), .OW(OW)) bus ();

    cmplx_mult_pipe #(.DW(DW), .TW(TW), .OW(OW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<300000", $time);
        $fatal(1, "watchdog");
    end

    // Reference: exact complex product, round half up (floor after +half), clamp.
    function automatic exp_t model(input longint ar, input longint ai, input longint wr,
                                   input longint wi, input bit cj);
        exp_t   e;
        longint re, im, rre, rim, hi, lo;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        re = cj ? ar * wr + ai * wi : ar * wr - ai * wi;
        im = cj ? ai * wr - ar * wi : ar * wi + ai * wr;
        rre = (re + (longint'(1) << (FRAC - 1))) >>> FRAC;
        rim = (im + (longint'(1) << (FRAC - 1))) >>> FRAC;
        e.sat = (rre > hi) || (rre < lo) || (rim > hi) || (rim < lo);
        if (rre > hi) rre = hi;
        if (rre < lo) rre = lo;
        if (rim > hi) rim = hi;
        if (rim < lo) rim = lo;
        e.re = OW'(rre);
        e.im = OW'(rim);
        return e;
    endfunction

    // Drive one beat with out_ready high and wait for its result.
    task automatic send_one(input int ar, input int ai, input int wr, input int wi, input bit cj,
                            output logic signed [OW-1:0] ore, output logic signed [OW-1:0] oim,
                            output int lat);
        @(negedge clk);
        bus.a_re = DW'(ar); bus.a_im = DW'(ai);
        bus.w_re = TW'(wr); bus.w_im = TW'(wi);
        bus.conj_en = cj; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = -1;
        ore = '0; oim = '0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = i + 1;
                ore = bus.out_re;
                oim = bus.out_im;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0; bus.conj_en = 1'b0;
        bus.a_re = '0; bus.a_im = '0; bus.w_re = '0; bus.w_im = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_re !== 16'sd0 || bus.out_im !== 16'sd0 ||
            bus.ovf_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid=%b re=%0d im=%0d cnt=%0d in_ready=%b required 0/0/0/0/1",
                     bus.out_valid, bus.out_re, bus.out_im, bus.ovf_cnt, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic signed [OW-1:0] r, i;
        int lat;
        send_one(16384, 0, 16384, 16384, 1'b0, r, i, lat);
        tests++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL latency: got %0d required 3", lat);
        end
        tests++;
        if (r !== 16'sd8192 || i !== 16'sd8192 || bus.ovf_cnt !== 16'd0) begin
            fails++;
            $display("FAIL basic_mult: got (%0d,%0d) cnt=%0d required (8192,8192) cnt=0", r, i, bus.ovf_cnt);
        end
        send_one(0, 16384, 0, 16384, 1'b0, r, i, lat);
        tests++;
        if (r !== -16'sd8192 || i !== 16'sd0) begin
            fails++;
            $display("FAIL normal_mode: got (%0d,%0d) required (-8192,0)", r, i);
        end
        send_one(0, 16384, 0, 16384, 1'b1, r, i, lat);
        tests++;
        if (r !== 16'sd8192 || i !== 16'sd0) begin
            fails++;
            $display("FAIL conj_mode: got (%0d,%0d) required (8192,0)", r, i);
        end
        send_one(3000, -7000, 12000, 9000, 1'b1, r, i, lat);
        tests++;
        if (r !== model(3000, -7000, 12000, 9000, 1'b1).re || i !== model(3000, -7000, 12000, 9000, 1'b1).im) begin
            fails++;
            $display("FAIL conj_mixed: got (%0d,%0d) required (%0d,%0d)", r, i,
                     model(3000, -7000, 12000, 9000, 1'b1).re, model(3000, -7000, 12000, 9000, 1'b1).im);
        end
    endtask

    task automatic test_rounding();
        logic signed [OW-1:0] r, i;
        int lat;
        send_one(1, 0, 16384, 0, 1'b0, r, i, lat);
        tests++;
        if (r !== 16'sd1) begin
            fails++;
            $display("FAIL round_pos_half: got %0d required 1", r);
        end
        send_one(-1, 0, 16384, 0, 1'b0, r, i, lat);
        tests++;
        if (r !== 16'sd0) begin
            fails++;
            $display("FAIL round_neg_half: got %0d required 0", r);
        end
    endtask

    task automatic test_saturation();
        logic signed [OW-1:0] r, i;
        int lat;
        send_one(-32768, 0, -32768, 0, 1'b0, r, i, lat);
        tests++;
        if (r !== 16'sd32767 || i !== 16'sd0) begin
            fails++;
            $display("FAIL sat_re: got (%0d,%0d) required (32767,0)", r, i);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.ovf_cnt !== 16'd1) begin
            fails++;
            $display("FAIL ovf_inc1: got %0d required 1", bus.ovf_cnt);
        end
        send_one(-32768, -32768, -32768, -32768, 1'b0, r, i, lat);
        tests++;
        if (r !== 16'sd0 || i !== 16'sd32767) begin
            fails++;
            $display("FAIL sat_im: got (%0d,%0d) required (0,32767)", r, i);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.ovf_cnt !== 16'd2) begin
            fails++;
            $display("FAIL ovf_inc2: got %0d required 2", bus.ovf_cnt);
        end
        send_one(-32768, 0, -32768, 0, 1'b0, r, i, lat);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        tests++;
        if (bus.ovf_cnt !== 16'd0) begin
            fails++;
            $display("FAIL ovf_clr_priority: got %0d required 0", bus.ovf_cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int   sent, got, cyc, stall_bad, ready_bad;
        int   exp_cnt;
        bit   held;
        logic signed [OW-1:0] hre, him;
        int   ar, ai, wr, wi;
        bit   cj;
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        exp_cnt = 0; sent = 0; got = 0; stall_bad = 0; ready_bad = 0; held = 1'b0;
        hre = '0; him = '0;
        for (cyc = 0; cyc < 600 && got < 20; cyc++) begin
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                ar = int'($urandom_range(0, 65535)) - 32768;
                ai = int'($urandom_range(0, 65535)) - 32768;
                wr = int'($urandom_range(0, 65535)) - 32768;
                wi = int'($urandom_range(0, 65535)) - 32768;
                cj = 1'($urandom_range(0, 1));
                bus.a_re = DW'(ar); bus.a_im = DW'(ai);
                bus.w_re = TW'(wr); bus.w_im = TW'(wi);
                bus.conj_en = cj; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = (sent >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) ready_bad++;
            if (held && (bus.out_valid !== 1'b1 || bus.out_re !== hre || bus.out_im !== him)) stall_bad++;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(ar, ai, wr, wi, cj));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: unexpected output (%0d,%0d) required none", bus.out_re, bus.out_im);
                end else begin
                    e = q.pop_front();
                    if (e.sat && exp_cnt < 65535) exp_cnt++;
                    if (bus.out_re !== e.re || bus.out_im !== e.im) begin
                        fails++;
                        $display("FAIL stream_beat%0d: got (%0d,%0d) required (%0d,%0d)",
                                 got, bus.out_re, bus.out_im, e.re, e.im);
                    end
                end
                got++;
            end
            held = bus.out_valid && !bus.out_ready;
            hre = bus.out_re; him = bus.out_im;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests++;
        if (got != 20) begin
            fails++;
            $display("FAIL stream_count: got %0d beats required 20", got);
        end
        tests++;
        if (stall_bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d unstable cycles required 0", stall_bad);
        end
        tests++;
        if (ready_bad != 0) begin
            fails++;
            $display("FAIL in_ready_rule: %0d wrong cycles required 0", ready_bad);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.ovf_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL stream_ovf_cnt: got %0d required %0d", bus.ovf_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [OW-1:0] r, i;
        int lat, spurious;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a_re = DW'(1000 + k); bus.a_im = DW'(-500); bus.w_re = 16'sd16384; bus.w_im = 16'sd100;
            bus.conj_en = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_re !== 16'sd0 || bus.out_im !== 16'sd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: valid=%b re=%0d im=%0d in_ready=%b required 0/0/0/1",
                     bus.out_valid, bus.out_re, bus.out_im, bus.in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        spurious = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) spurious++;
        end
        tests++;
        if (spurious != 0) begin
            fails++;
            $display("FAIL flushed_beats: %0d stale outputs required 0", spurious);
        end
        send_one(-20000, 12345, 23170, -23170, 1'b0, r, i, lat);
        tests++;
        if (lat !== 3 || r !== model(-20000, 12345, 23170, -23170, 1'b0).re ||
            i !== model(-20000, 12345, 23170, -23170, 1'b0).im) begin
            fails++;
            $display("FAIL post_reset_beat: lat=%0d got (%0d,%0d) required lat=3 (%0d,%0d)", lat, r, i,
                     model(-20000, 12345, 23170, -23170, 1'b0).re, model(-20000, 12345, 23170, -23170, 1'b0).im);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
